// File: rtl/packet_builder.sv
// Packs one message per handshake into a 32-bit word stream: a length/stream header,
// a sequence header, then zero-padded payload words. Each stream has its own sequence counter.
module packet_builder #(
   parameter int NUM_STREAMS = 16,
   parameter int MAX_PAYLOAD = 36,
   parameter int SEQ_W       = 32
) (
   input  logic                       clk,
   input  logic                       reset_b,
   input  logic [15:0]                msgIn_stream,
   input  logic [15:0]                msgIn_len,
   input  logic [0:MAX_PAYLOAD*8-1]   msgIn_data,
   input  logic                       msgIn_val,
   output logic                       msgIn_ready,
   output logic                       msgIn_err,
   output logic [31:0]                dataOut,
   output logic                       dataOut_val,
   input  logic                       dataOut_ready,
   output logic                       dataOut_last
);

   // state   | meaning
   // IDLE    | ready for a message; accepted message loads header word 0
   // HDR0    | length/stream word presented
   // HDR1    | sequence word presented (final word when len=0)
   // PAYLOAD | payload words presented, one per transfer
   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_HDR0    = 2'd1;
   localparam logic [1:0] S_HDR1    = 2'd2;
   localparam logic [1:0] S_PAYLOAD = 2'd3;

   localparam int NUM_WORDS = (MAX_PAYLOAD + 3) / 4;
   localparam int IDX_W     = $clog2(NUM_WORDS + 1);
   localparam int STREAM_W  = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

   localparam logic [15:0] MAX_LEN   = 16'(MAX_PAYLOAD);
   localparam logic [15:0] NUM_STR16 = 16'(NUM_STREAMS);

   logic [1:0]        state;
   logic [SEQ_W-1:0]  cnt [NUM_STREAMS];
   logic [SEQ_W-1:0]  seq_q;
   logic [IDX_W-1:0]  n_words;
   logic [IDX_W-1:0]  word_idx;
   logic [31:0]       pay_words [0:NUM_WORDS-1];

   logic              accept_try;
   logic              msg_bad;
   logic [STREAM_W-1:0] sidx;
   logic [15:0]       tot_len;
   logic [31:0]       hdr0_word;
   logic [31:0]       seq_ext;
   logic [31:0]       hdr1_word;

   assign accept_try = (state == S_IDLE) && msgIn_val;
   assign msg_bad    = (msgIn_stream >= NUM_STR16) || (msgIn_len > MAX_LEN);
   assign sidx       = msgIn_stream[STREAM_W-1:0];
   assign tot_len    = msgIn_len + 16'd8;
   assign hdr0_word  = {tot_len[7:0], tot_len[15:8], msgIn_stream[7:0], msgIn_stream[15:8]};
   assign seq_ext    = 32'(seq_q);
   assign hdr1_word  = {seq_ext[7:0], seq_ext[15:8], seq_ext[23:16], seq_ext[31:24]};

   // Bytes at or beyond len are forced to zero so the last word is padded cleanly.
   function automatic logic [31:0] pack_word(input logic [0:MAX_PAYLOAD*8-1] data,
                                             input logic [15:0] len, input int w);
      logic [31:0] word;
      int k;
      word = '0;
      for (int b = 0; b < 4; b++) begin
         k = 4 * w + b;
         if (k < MAX_PAYLOAD && 16'(k) < len)
            word[31-8*b -: 8] = data[8*k +: 8];
      end
      return word;
   endfunction

   always_ff @(posedge clk) begin
      if (accept_try && !msg_bad) begin
         for (int w = 0; w < NUM_WORDS; w++)
            pay_words[w] <= pack_word(msgIn_data, msgIn_len, w);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_b) begin
         state        <= S_IDLE;
         msgIn_ready  <= 1'b1;
         msgIn_err    <= 1'b0;
         dataOut      <= '0;
         dataOut_val  <= 1'b0;
         dataOut_last <= 1'b0;
         seq_q        <= '0;
         n_words      <= '0;
         word_idx     <= '0;
         for (int i = 0; i < NUM_STREAMS; i++)
            cnt[i] <= SEQ_W'(1);
      end else begin
         msgIn_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (msgIn_val) begin
                  if (msg_bad) begin
                     msgIn_err <= 1'b1;
                  end else begin
                     seq_q        <= cnt[sidx];
                     cnt[sidx]    <= cnt[sidx] + SEQ_W'(1);
                     n_words      <= IDX_W'((msgIn_len + 16'd3) >> 2);
                     word_idx     <= '0;
                     dataOut      <= hdr0_word;
                     dataOut_val  <= 1'b1;
                     dataOut_last <= 1'b0;
                     msgIn_ready  <= 1'b0;
                     state        <= S_HDR0;
                  end
               end
            end
            S_HDR0: begin
               if (dataOut_ready) begin
                  dataOut      <= hdr1_word;
                  dataOut_last <= (n_words == '0);
                  state        <= S_HDR1;
               end
            end
            S_HDR1: begin
               if (dataOut_ready) begin
                  if (n_words == '0) begin
                     dataOut      <= '0;
                     dataOut_val  <= 1'b0;
                     dataOut_last <= 1'b0;
                     msgIn_ready  <= 1'b1;
                     state        <= S_IDLE;
                  end else begin
                     dataOut      <= pay_words[0];
                     dataOut_last <= (n_words == IDX_W'(1));
                     word_idx     <= IDX_W'(1);
                     state        <= S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (dataOut_ready) begin
                  if (dataOut_last) begin
                     dataOut      <= '0;
                     dataOut_val  <= 1'b0;
                     dataOut_last <= 1'b0;
                     msgIn_ready  <= 1'b1;
                     state        <= S_IDLE;
                  end else begin
                     dataOut      <= pay_words[word_idx];
                     dataOut_last <= (word_idx == n_words - IDX_W'(1));
                     word_idx     <= word_idx + IDX_W'(1);
                  end
               end
            end
            default: begin
               state        <= S_IDLE;
               dataOut_val  <= 1'b0;
               dataOut_last <= 1'b0;
               msgIn_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule
